// File: rtl/axi_write_arbiter_rr_pkg.sv
// axi_arb_pkg: shared types, widths and round-robin search for the AXI arbiters
package axi_arb_pkg;
  localparam int NUM_M = 4;
  localparam int LEN_W = 8;
  typedef enum logic [1:0] {IDLE, AW, W, B} arb_state_t;
  typedef struct packed {
    logic [1:0] idx;
    logic       found;
  } pick_t;
  // first requester at or after ptr, wrapping modulo 4
  function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] j;
    rr_pick = '0;
    for (int i = 0; i < 4; i++) begin
      j = ptr + 2'(i);
      if (req[j] && !rr_pick.found) begin
        rr_pick.idx   = j;
        rr_pick.found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/axi_write_arbiter_rr_if.sv
// axi_write_arbiter_rr_if: request/handshake inputs and grant/routing outputs of the write arbiter
interface axi_write_arbiter_rr_if #(parameter int LEN_W = axi_arb_pkg::LEN_W);
  logic m0_AWVALID, m1_AWVALID, m2_AWVALID, m3_AWVALID;
  logic m0_WVALID, m1_WVALID, m2_WVALID, m3_WVALID;
  logic m0_WLAST, m1_WLAST, m2_WLAST, m3_WLAST;
  logic m0_BREADY, m1_BREADY, m2_BREADY, m3_BREADY;
  logic s_AWREADY, s_WREADY, s_BVALID;
  logic [LEN_W-1:0] s_AWLEN;
  logic m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt;
  logic [1:0] wsel;
  logic aw_en, w_en, b_en, len_err;
  modport slave (
    input  m0_AWVALID, m1_AWVALID, m2_AWVALID, m3_AWVALID,
    input  m0_WVALID, m1_WVALID, m2_WVALID, m3_WVALID,
    input  m0_WLAST, m1_WLAST, m2_WLAST, m3_WLAST,
    input  m0_BREADY, m1_BREADY, m2_BREADY, m3_BREADY,
    input  s_AWREADY, s_WREADY, s_BVALID, s_AWLEN,
    output m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt,
    output wsel, aw_en, w_en, b_en, len_err
  );
  modport master (
    output m0_AWVALID, m1_AWVALID, m2_AWVALID, m3_AWVALID,
    output m0_WVALID, m1_WVALID, m2_WVALID, m3_WVALID,
    output m0_WLAST, m1_WLAST, m2_WLAST, m3_WLAST,
    output m0_BREADY, m1_BREADY, m2_BREADY, m3_BREADY,
    output s_AWREADY, s_WREADY, s_BVALID, s_AWLEN,
    input  m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt,
    input  wsel, aw_en, w_en, b_en, len_err
  );
endinterface

// File: rtl/axi_write_arbiter_rr_picker.sv
// axi_rr_picker: combinational round-robin winner search, shared with the read arbiter
module axi_rr_picker
  import axi_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);
  pick_t p;
  assign p     = rr_pick(req, ptr);
  assign idx   = p.idx;
  assign found = p.found;
endmodule

// File: rtl/axi_write_arbiter_rr.sv
// axi_write_arbiter_rr: round-robin four-master AXI write arbiter holding the grant for a whole AW/W/B transaction
module axi_write_arbiter_rr #(
  parameter int NUM_M = axi_arb_pkg::NUM_M,
  parameter int LEN_W = axi_arb_pkg::LEN_W
) (
  input logic ACLK,
  input logic ARESET,
  axi_write_arbiter_rr_if.slave bus
);
  import axi_arb_pkg::*;
  arb_state_t state_q, state_d;
  logic [NUM_M-1:0] awv, wv, wl, br, grnt_q, grnt_d;
  logic [1:0] wsel_q, wsel_d, ptr_q, ptr_d, pick_idx;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic len_err_q, len_err_d, pick_found;
  logic aw_hs, w_beat, b_hs, g_wlast;
  assign awv = {bus.m3_AWVALID, bus.m2_AWVALID, bus.m1_AWVALID, bus.m0_AWVALID};
  assign wv  = {bus.m3_WVALID, bus.m2_WVALID, bus.m1_WVALID, bus.m0_WVALID};
  assign wl  = {bus.m3_WLAST, bus.m2_WLAST, bus.m1_WLAST, bus.m0_WLAST};
  assign br  = {bus.m3_BREADY, bus.m2_BREADY, bus.m1_BREADY, bus.m0_BREADY};
  assign aw_hs   = awv[wsel_q] & bus.s_AWREADY;
  assign w_beat  = wv[wsel_q] & bus.s_WREADY;
  assign b_hs    = br[wsel_q] & bus.s_BVALID;
  assign g_wlast = wl[wsel_q];
  axi_rr_picker u_picker (
    .req   (awv),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      grnt_q    <= '0;
      wsel_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grnt_q    <= grnt_d;
      wsel_q    <= wsel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    grnt_d    = grnt_q;
    wsel_d    = wsel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    len_err_d = 1'b0;
    unique case (state_q)
      IDLE: if (pick_found) begin
        state_d          = AW;
        grnt_d           = '0;
        grnt_d[pick_idx] = 1'b1;
        wsel_d           = pick_idx;
      end
      AW: if (aw_hs) begin
        state_d = W;
        cnt_d   = '0;
        len_d   = bus.s_AWLEN;
      end
      // WLAST alone ends the burst; the count only flags a length mismatch
      W: if (w_beat) begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        if (g_wlast) begin
          state_d   = B;
          len_err_d = cnt_q != len_q;
        end
      end
      B: if (b_hs) begin
        state_d = IDLE;
        grnt_d  = '0;
        ptr_d   = wsel_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    {bus.m3_wgrnt, bus.m2_wgrnt, bus.m1_wgrnt, bus.m0_wgrnt} = grnt_q;
    bus.wsel    = wsel_q;
    bus.aw_en   = state_q == AW;
    bus.w_en    = state_q == W;
    bus.b_en    = state_q == B;
    bus.len_err = len_err_q;
  end
endmodule

// File: doc/axi_write_arbiter_rr.md
# axi_write_arbiter_rr

Round-robin write-channel arbiter for four AXI bus masters in front of the shared slave port of the interconnect. Grants one master at a time and holds the grant for a complete write transaction (AW handshake, W burst through WLAST, B handshake), then rotates priority. Its grant and channel-enable outputs drive the downstream AW/W/B multiplexers feeding a single AXI_Slave-class target.

## Interface
Parameters:
- NUM_M, 4, number of masters; fixed at 4 in this revision, kept as a parameter for the package width constants.
- LEN_W, 8, width of AWLEN and the internal beat counter.

Ports:
- ACLK  in  1  clock; everything registers on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- m0_AWVALID..m3_AWVALID  in  1 each  per-master write-address request.
- m0_WVALID..m3_WVALID  in  1 each  per-master write-data valid.
- m0_WLAST..m3_WLAST  in  1 each  per-master last-beat flag.
- m0_BREADY..m3_BREADY  in  1 each  per-master response ready.
- s_AWREADY  in  1  slave address ready.
- s_WREADY  in  1  slave data ready.
- s_BVALID  in  1  slave response valid.
- s_AWLEN  in  LEN_W  AWLEN of the granted master, already muxed by the grant.
- m0_wgrnt..m3_wgrnt  out  1 each  one-hot grant, held for the whole transaction.
- wsel  out  2  binary index of the granted master; valid while any grant is high.
- aw_en  out  1  AW channel routed, meaning state AW.
- w_en  out  1  W channel routed, meaning state W.
- b_en  out  1  B channel routed, meaning state B.
- len_err  out  1  one-cycle pulse when the WLAST beat count mismatches AWLEN+1.

## Operation
- FSM states: IDLE, AW, W, B. All outputs are registered.
- Selected-master signals: g_AWVALID, g_WVALID, g_WLAST and g_BREADY are the granted master's inputs, selected by wsel.
- IDLE:
  - If any mN_AWVALID is high, pick the first requester scanning upward from ptr, wrapping modulo 4.
  - Set that master's grant and wsel, then go to AW.
  - Requests that drop while in IDLE are ignored.
- AW:
  - Wait for g_AWVALID & s_AWREADY.
  - On that handshake, load cnt = 0, latch len = s_AWLEN, and go to W.
- W:
  - Each g_WVALID & s_WREADY beat increments cnt.
  - On a beat with g_WLAST high, go to B.
  - If cnt != len on that beat, pulse len_err for one cycle.
  - A beat where cnt reaches len but WLAST is low does not end the burst. The arbiter trusts WLAST, and the count saturates at its maximum.
- B:
  - Wait for s_BVALID & g_BREADY.
  - Then go to IDLE, clear all grants, and set ptr = wsel+1 modulo 4.
- Grant rules:
  - Grants never change outside IDLE.
  - Requests from other masters during a transaction are held off, with no preemption and no timeout.
- W data presented by the granted master before the AW handshake is not routed, because w_en is low. The mux keeps WREADY to the master low.

## Timing
- Reset values (effective the cycle after ARESET is sampled high):
  - state = IDLE, all grants 0, wsel 0, ptr 0.
  - aw_en, w_en, b_en, len_err all 0; cnt and len 0.
- Reset asserted mid-transaction aborts immediately to these values. There is no completion of an outstanding burst.
- Request to grant: one cycle. AWVALID sampled in cycle N gives the grant and aw_en high in cycle N+1.
- AW handshake in cycle N: aw_en drops and w_en rises in N+1.
- Last W beat in cycle N: b_en rises in N+1; len_err, if any, pulses in N+1.
- B handshake in cycle N: grants and b_en drop in N+1. The earliest next grant is N+2, so there is at least one IDLE cycle between transactions.
- Single-beat burst (AWLEN = 0 with WLAST on the first beat): no error.
- Simultaneous requests in IDLE: exactly one grant, the winner by ptr order.

## Structure
- Shared package axi_arb_pkg holds:
  - the state enum type arb_state_t (IDLE, AW, W, B);
  - NUM_M and LEN_W localparams;
  - function rr_pick(req[3:0], ptr[1:0]) returning the winner index and a found flag.
- One sub-module, axi_rr_picker, implements the combinational round-robin search. It is shared with the future read arbiter.
- Counter, FSM and output registers stay in the top module.

## Test plan
- Single master: m0 requests with AWLEN = 3 and sends 4 beats, WLAST on the 4th. Expect m0_wgrnt high from the cycle after AWVALID until the cycle after the B handshake, w_en high for exactly the W phase, len_err never pulsing, and ptr = 1 afterwards.
- All four masters request simultaneously from reset. Expect grant order m0, m1, m2, m3, with one IDLE cycle between transactions and exactly one grant high at any time.
- m2 is mid-burst while m1 and m3 request. Expect no grant change until m2's B handshake, then m3 (ptr = 3) before m1.
- m0 sends AWLEN = 15 but WLAST on beat 10. Expect a len_err pulse one cycle after the 10th beat and the state going to B.
- ARESET asserted during m1's W phase after beat 5. Expect all outputs zero the next cycle, and a subsequent m1 request granted cleanly with the counter restarted at 0.
- s_AWREADY held low for 5 cycles, then s_BVALID asserted before BREADY. Expect aw_en held for 5 cycles and the grant held until both s_BVALID and BREADY are high.
